// File: rtl/gpio_reg_ctrl_if.sv
// CPU-side register bus for gpio_reg_ctrl: sel/we request, one-cycle ready completion.
interface gpio_reg_ctrl_if;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  logic              sel;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output sel, we, addr, wdata, input rdata, ready);
  modport slave  (input sel, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/gpio_reg_ctrl.sv
// Register-mapped controller for fnc_gpio: output latch, filter/prescaler
// configuration, input sampling and edge interrupts behind a 2-cycle bus.
module gpio_reg_ctrl #(
  parameter logic [7:0] DFLT_RST   = 8'd5,
  parameter logic [7:0] REFCLK_RST = 8'd2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gpio_reg_ctrl_if.slave        bus,
  output logic [7:0]            gpio_out,
  input  logic [15:0]           gpio_in,
  output logic [7:0]            dflt_st,
  output logic [7:0]            refclk_st,
  output logic                  irq
);

  localparam int unsigned OUT_W  = 8;
  localparam int unsigned IN_W   = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] A_OUT = 3'd0;
  localparam logic [ADDR_W-1:0] A_SET = 3'd1;
  localparam logic [ADDR_W-1:0] A_CLR = 3'd2;
  localparam logic [ADDR_W-1:0] A_IN  = 3'd3;
  localparam logic [ADDR_W-1:0] A_CFG = 3'd4;
  localparam logic [ADDR_W-1:0] A_IE  = 3'd5;
  localparam logic [ADDR_W-1:0] A_ISR = 3'd6;

  typedef enum logic {IDLE, ACK} state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                latch_c, commit_c;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [IN_W-1:0]     in_q;
  logic [2*IN_W-1:0]   ie_q;
  logic [IN_W-1:0]     isr_q;
  logic [DATA_W-1:0]   rd_mux_c;
  logic [IN_W-1:0]     rise_c, fall_c, set_c, clr_c;
  logic                wr_c;

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

  // Read view of the register map, indexed by the address presented in IDLE.
  always_comb begin
    rd_mux_c = '0;
    case (bus.addr)
      A_OUT:   rd_mux_c = DATA_W'(gpio_out);
      A_IN:    rd_mux_c = DATA_W'(in_q);
      A_CFG:   rd_mux_c = DATA_W'({refclk_st, dflt_st});
      A_IE:    rd_mux_c = ie_q;
      A_ISR:   rd_mux_c = DATA_W'(isr_q);
      default: rd_mux_c = '0;
    endcase
  end

  // Bus FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus FSM next state: IDLE accepts a request, ACK completes it and commits.
  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    rdata_d  = '0;
    latch_c  = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sel) begin
          state_d = ACK;
          ready_d = 1'b1;
          latch_c = 1'b1;
          rdata_d = bus.we ? '0 : rd_mux_c;
        end
      end
      ACK: begin
        state_d  = IDLE;
        commit_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture so the write can commit when ACK is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (latch_c) begin
      addr_q  <= bus.addr;
      we_q    <= bus.we;
      wdata_q <= bus.wdata;
    end
  end

  assign wr_c = commit_c & we_q;

  // Output latch with direct, set and clear write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out <= '0;
    end else if (wr_c) begin
      case (addr_q)
        A_OUT:   gpio_out <= wdata_q[OUT_W-1:0];
        A_SET:   gpio_out <= gpio_out | wdata_q[OUT_W-1:0];
        A_CLR:   gpio_out <= gpio_out & ~wdata_q[OUT_W-1:0];
        default: gpio_out <= gpio_out;
      endcase
    end
  end

  // Filter / prescaler configuration and interrupt enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dflt_st   <= DFLT_RST;
      refclk_st <= REFCLK_RST;
      ie_q      <= '0;
    end else if (wr_c) begin
      if (addr_q == A_CFG) begin
        dflt_st   <= wdata_q[7:0];
        refclk_st <= wdata_q[15:8];
      end
      if (addr_q == A_IE) begin
        ie_q <= wdata_q;
      end
    end
  end

  assign rise_c = gpio_in & ~in_q;
  assign fall_c = ~gpio_in & in_q;
  assign set_c  = (rise_c & ie_q[IN_W-1:0]) | (fall_c & ie_q[2*IN_W-1:IN_W]);
  assign clr_c  = (wr_c && addr_q == A_ISR) ? wdata_q[IN_W-1:0] : '0;

  // Input sampling, pending edges (a set beats a same-cycle clear) and irq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '0;
      isr_q <= '0;
      irq   <= 1'b0;
    end else begin
      in_q  <= gpio_in;
      isr_q <= set_c | (isr_q & ~clr_c);
      irq   <= |isr_q;
    end
  end

endmodule

// File: tb/tb_gpio_reg_ctrl.sv
// Self-checking bench for gpio_reg_ctrl: directed table, corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_gpio_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] gpio_in = '0;
  logic [7:0]  gpio_out, dflt_st, refclk_st;
  logic        irq;

  gpio_reg_ctrl_if bus ();

  gpio_reg_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .gpio_out  (gpio_out),
    .gpio_in   (gpio_in),
    .dflt_st   (dflt_st),
    .refclk_st (refclk_st),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state (what the register map should hold right now).
  logic [7:0]  m_out, m_dflt, m_ref;
  logic [31:0] m_ie;
  logic [15:0] m_isr, m_inq;
  logic        m_irq;
  // Write waiting to commit at the next edge.
  logic        p_valid;
  logic [2:0]  p_addr;
  logic [31:0] p_wdata;
  // Optional gpio_in change applied during the ACK cycle of the next access.
  logic        ack_gin_en = 1'b0;
  logic [15:0] ack_gin = '0;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 8'h00; m_dflt = 8'd5; m_ref = 8'd2;
    m_ie = '0; m_isr = '0; m_inq = '0; m_irq = 1'b0;
    p_valid = 1'b0; p_addr = '0; p_wdata = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'h0, m_out};
      3'd3: return {16'h0, m_inq};
      3'd4: return {16'h0, m_ref, m_dflt};
      3'd5: return m_ie;
      3'd6: return {16'h0, m_isr};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: advance the model by the register-map rules, then compare outputs.
  task automatic tick();
    logic [15:0] gin, rise, fall, setm, clrm;
    @(posedge clk);
    gin  = gpio_in;
    rise = gin & ~m_inq;
    fall = ~gin & m_inq;
    setm = (rise & m_ie[15:0]) | (fall & m_ie[31:16]);
    clrm = '0;
    m_irq = (m_isr != 16'h0);
    if (p_valid) begin
      case (p_addr)
        3'd0: m_out = p_wdata[7:0];
        3'd1: m_out = m_out | p_wdata[7:0];
        3'd2: m_out = m_out & ~p_wdata[7:0];
        3'd4: begin m_dflt = p_wdata[7:0]; m_ref = p_wdata[15:8]; end
        3'd5: m_ie = p_wdata;
        3'd6: clrm = p_wdata[15:0];
        default: ;
      endcase
      p_valid = 1'b0;
    end
    m_isr = setm | (m_isr & ~clrm);
    m_inq = gin;
    #1;
    chk("gpio_out", 32'(gpio_out), 32'(m_out));
    chk("dflt_st", 32'(dflt_st), 32'(m_dflt));
    chk("refclk_st", 32'(refclk_st), 32'(m_ref));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  // One bus access: sel in IDLE, ready/rdata in ACK, write commits leaving ACK.
  task automatic access(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd);
    logic [31:0] exp;
    bus.sel = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata;
    exp = model_read(addr);
    tick();
    chk("ready_ack", 32'(bus.ready), 32'd1);
    rd = bus.rdata;
    if (!we) chk("rdata", rd, exp);
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    if (ack_gin_en) begin
      gpio_in = ack_gin;
      ack_gin_en = 1'b0;
    end
    if (we) begin
      p_valid = 1'b1; p_addr = addr; p_wdata = wdata;
    end
    tick();
    chk("ready_done", 32'(bus.ready), 32'd0);
    chk("rdata_idle", bus.rdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    model_reset();

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gpio_out", 32'(gpio_out), 32'h00);
    chk("rst_dflt", 32'(dflt_st), 32'h05);
    chk("rst_refclk", 32'(refclk_st), 32'h02);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed register-map table.
    tbl.push_back('{1'b0, 3'd4, 32'h0,         32'h0000_0205, 8'h00});
    tbl.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_0000, 8'h00});
    tbl.push_back('{1'b1, 3'd0, 32'h0000_0055, 32'h0,         8'h55});
    tbl.push_back('{1'b1, 3'd1, 32'h0000_000A, 32'h0,         8'h5F});
    tbl.push_back('{1'b0, 3'd1, 32'h0,         32'h0000_0000, 8'h5F});
    tbl.push_back('{1'b1, 3'd2, 32'h0000_0041, 32'h0,         8'h1E});
    tbl.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_001E, 8'h1E});
    tbl.push_back('{1'b0, 3'd2, 32'h0,         32'h0000_0000, 8'h1E});
    tbl.push_back('{1'b1, 3'd4, 32'hFFFF_3107, 32'h0,         8'h1E});
    tbl.push_back('{1'b0, 3'd4, 32'h0,         32'h0000_3107, 8'h1E});
    tbl.push_back('{1'b1, 3'd3, 32'h0000_FFFF, 32'h0,         8'h1E});
    tbl.push_back('{1'b0, 3'd3, 32'h0,         32'h0000_0000, 8'h1E});
    tbl.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0,         8'h1E});
    tbl.push_back('{1'b0, 3'd7, 32'h0,         32'h0000_0000, 8'h1E});
    tbl.push_back('{1'b0, 3'd6, 32'h0,         32'h0000_0000, 8'h1E});
    tbl.push_back('{1'b1, 3'd0, 32'h0000_01FF, 32'h0,         8'hFF});
    tbl.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_00FF, 8'hFF});
    tbl.push_back('{1'b1, 3'd5, 32'h0001_0001, 32'h0,         8'hFF});
    tbl.push_back('{1'b0, 3'd5, 32'h0,         32'h0001_0001, 8'hFF});
    foreach (tbl[i]) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
      if (!tbl[i].we) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_out", i), 32'(gpio_out), 32'(tbl[i].exp_out));
    end

    // Rise on bit0 -> ISR next cycle, irq one cycle later; W1C drops it; fall sets again.
    gpio_in = 16'h0001;
    tick();
    chk("rise_irq_lag", 32'(irq), 32'd0);
    tick();
    chk("rise_irq", 32'(irq), 32'd1);
    access(1'b0, 3'd6, 32'h0, rd);
    chk("rise_isr", rd, 32'h0000_0001);
    access(1'b1, 3'd6, 32'h1, rd);
    tick();
    chk("w1c_irq_low", 32'(irq), 32'd0);
    gpio_in = 16'h0000;
    tick();
    tick();
    chk("fall_irq", 32'(irq), 32'd1);
    access(1'b0, 3'd6, 32'h0, rd);
    chk("fall_isr", rd, 32'h0000_0001);
    access(1'b1, 3'd6, 32'h1, rd);
    tick();

    // Edges with IE=0 are lost.
    access(1'b1, 3'd5, 32'h0, rd);
    gpio_in = 16'hFFFF; tick();
    gpio_in = 16'h0000; tick();
    gpio_in = 16'hFFFF; tick(); tick();
    chk("ie0_irq", 32'(irq), 32'd0);
    access(1'b0, 3'd6, 32'h0, rd);
    chk("ie0_isr", rd, 32'h0);
    access(1'b0, 3'd3, 32'h0, rd);
    chk("in_read", rd, 32'h0000_FFFF);

    // Same-edge set and W1C on bit3: set wins, irq stays high.
    gpio_in = 16'h0000; tick();
    access(1'b1, 3'd5, 32'h0000_0008, rd);
    gpio_in = 16'h0008; tick();
    gpio_in = 16'h0000; tick(); tick();
    chk("b3_irq", 32'(irq), 32'd1);
    ack_gin_en = 1'b1; ack_gin = 16'h0008;
    access(1'b1, 3'd6, 32'h0000_0008, rd);
    chk("same_cyc_irq", 32'(irq), 32'd1);
    tick();
    chk("same_cyc_irq2", 32'(irq), 32'd1);
    access(1'b0, 3'd6, 32'h0, rd);
    chk("same_cyc_isr", rd, 32'h0000_0008);
    access(1'b1, 3'd6, 32'h0000_0008, rd);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int idle;
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) begin
        if ($urandom_range(0, 1) == 1) gpio_in = 16'($urandom);
        tick();
      end
      if ($urandom_range(0, 3) == 0) begin
        ack_gin_en = 1'b1; ack_gin = 16'($urandom);
      end
      access(1'($urandom), 3'($urandom), $urandom, rd);
    end

    // Make OUT nonzero, then reset in the ACK of a write OUT=AA.
    access(1'b1, 3'd0, 32'h0000_0033, rd);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = 3'd0; bus.wdata = 32'h0000_00AA;
    tick();
    chk("abort_ready_ack", 32'(bus.ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_gpio_out", 32'(gpio_out), 32'h00);
    chk("abort_ready", 32'(bus.ready), 32'd0);
    chk("abort_rdata", bus.rdata, 32'd0);
    chk("abort_dflt", 32'(dflt_st), 32'h05);
    chk("abort_irq", 32'(irq), 32'd0);
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    gpio_in = 16'h0000;
    model_reset();
    @(posedge clk);
    #1;
    chk("abort_hold_ready", 32'(bus.ready), 32'd0);
    chk("abort_hold_out", 32'(gpio_out), 32'h00);
    rst_n = 1'b1;
    tick();
    access(1'b0, 3'd0, 32'h0, rd);
    chk("abort_out_read", rd, 32'h0);
    access(1'b0, 3'd4, 32'h0, rd);
    chk("abort_cfg_read", rd, 32'h0000_0205);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_reg_ctrl.md
Name: gpio_reg_ctrl

Overview:
Register-mapped controller for fnc_gpio. It owns the output latch (gpio_out) and the filter/prescaler configuration (dflt_st, refclk_st), and samples the filtered inputs (gpio_in). It generates a level interrupt on enabled rising and falling input edges. A simple sel/we/ready bus connects it to the CPU peripheral bus.

Parameters:
DFLT_RST, 8'd5, reset value of dflt_st
REFCLK_RST, 8'd2, reset value of refclk_st

Ports:
clk  in  1  global clock
rst_n  in  1  asynchronous active-low reset
sel  in  1  bus access request; held high until ready
we  in  1  1 = write, 0 = read; valid while sel
addr  in  3  word register index
wdata  in  32  write data
rdata  out  32  read data; valid only while ready=1, else 32'h0
ready  out  1  one-cycle access completion strobe
gpio_out  out  8  output latch, to fnc_gpio
gpio_in  in  16  filtered input state, from fnc_gpio
dflt_st  out  8  digital filter setting, to fnc_gpio
refclk_st  out  8  clock divider setting, to fnc_gpio
irq  out  1  interrupt request, active high

Behaviour:
- Reset (async, rst_n=0) puts every state element in its reset state immediately:
  - gpio_out=0, dflt_st=DFLT_RST, refclk_st=REFCLK_RST, IE=0, ISR=0
  - in_q=0, irq=0, ready=0, rdata=0, FSM=IDLE
- Register map (unused bits read 0, writes to them are ignored):
  - 0 OUT, RW: [7:0] gpio_out
  - 1 SET, WO: gpio_out |= wdata[7:0]; reads 0
  - 2 CLR, WO: gpio_out &= ~wdata[7:0]; reads 0
  - 3 IN, RO: [15:0] in_q; writes ignored
  - 4 CFG, RW: [7:0] dflt_st, [15:8] refclk_st
  - 5 IE, RW: [15:0] rising-edge enable, [31:16] falling-edge enable
  - 6 ISR, R/W1C: [15:0] pending; writing 1 clears the bit, writing 0 has no effect
  - 7 reserved: reads 0, writes ignored
- Bus FSM, two states:
  - IDLE: when sel=1, latch addr/we/wdata and go to ACK.
  - ACK: ready=1 for exactly one cycle; rdata is driven from the latched addr. Writes commit at the clock edge that leaves ACK. Always return to IDLE.
  - Every access takes 2 cycles. sel still high in the IDLE cycle after ready starts a new access; the master drops sel after seeing ready.
  - A read in ACK returns register contents from before any write committing at that same edge.
  - Outputs gpio_out/dflt_st/refclk_st change at the commit edge, so fnc_gpio sees them one cycle after ready.
- Input sampling:
  - in_q <= gpio_in every cycle.
  - rise = gpio_in & ~in_q; fall = ~gpio_in & in_q.
- Interrupt:
  - set[i] = (rise[i] & IE[i]) | (fall[i] & IE[16+i]).
  - ISR[i] <= set[i] | (ISR[i] & ~clr[i]), where clr is the W1C mask at the commit edge. A set in the same cycle as a clear wins (the bit stays 1).
  - irq <= |ISR: registered, one cycle after ISR changes. It stays high until all pending bits are cleared.
  - Writing IE does not clear ISR. An edge arriving while its enable is 0 is lost; it is not latched for later.
- The first cycle after reset release with gpio_in nonzero produces rise events. These are ignored because IE=0.
- Reset asserted mid-access: the access is abandoned with no commit, and ready does not pulse.

Test Plan:
- Reset, then read CFG and OUT -> rdata=32'h0000_0205, then 32'h0. irq=0; ready pulses 1 cycle, 2 cycles after sel.
- Write OUT=8'h55, SET 8'h0A, CLR 8'h41 -> gpio_out goes 55 -> 5F -> 1E. Each change lands 1 cycle after its ready; reading SET returns 0.
- IE=32'h0001_0001, gpio_in 0->1 on bit0 -> ISR=1 next cycle, irq=1 one cycle later. W1C 1 -> ISR=0 and irq drops. Then 1->0 on bit0 -> ISR bit0 set again.
- IE=0, toggle gpio_in=16'hFFFF -> ISR stays 0 and irq stays 0. Read IN -> 32'h0000_FFFF.
- ISR bit3 pending, W1C 8 issued in the same cycle as a new enabled rise on bit3 -> ISR bit3 remains 1 and irq stays 1.
- Assert rst_n=0 during ACK of a write OUT=8'hAA -> gpio_out=0 and ready=0 immediately; after release, OUT reads 0.
